// File: rtl/nios_hps_system_spi_fifo.sv
// Avalon-MM SPI master with TX/RX FIFOs, runtime CPOL/CPHA/bit order and a programmable SCLK divider.
// SCLK half-period is (divider+1) clk cycles; all SPI pins and the bus read data are registered.
module nios_hps_system_spi_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NUM_SLAVES = 1,
    parameter int unsigned DIV_RESET  = 195
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_select,
    input  logic [2:0]            mem_addr,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic [15:0]           data_from_cpu,
    output logic [15:0]           data_to_cpu,
    output logic                  irq,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [NUM_SLAVES-1:0] SS_n
);
    localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW        = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [15:0]   WMASK     = 16'((32'd1 << DATA_W) - 32'd1);
    localparam logic [5:0]    LAST_EDGE = 6'(2 * DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LEAD, S_SHIFT, S_TRAIL} state_t;

    state_t                  state_q;
    logic [15:0]             cnt_q, div_l_q, div_q, tx_sh_q, rx_sh_q, dout_q;
    logic [5:0]              edge_q, edge_nx;
    logic                    cpol_l_q, cpha_l_q, lsb_l_q;
    logic                    sclk_q, mosi_q, toe_q, roe_q, irq_q;
    logic [NUM_SLAVES-1:0]   ss_n_q, mask_q, mask_l_q;
    logic [6:0]              ctrl_q;
    logic [15:0]             tx_mem [FIFO_DEPTH];
    logic [15:0]             rx_mem [FIFO_DEPTH];
    logic [AW-1:0]           tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]           tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
    logic                    wr_en, rd_en, hp_done, tx_empty, tx_full, rx_empty, rx_full;
    logic                    tx_pop, tx_push, tx_push_req, toe_set, rx_pop, rx_push, rx_push_req, roe_set;
    logic                    sample_now, shift_now;
    logic [3:0]              samp_idx;
    logic [15:0]             status;

    function automatic logic [3:0] bitpos(input logic lsb, input logic [3:0] idx);
        return lsb ? idx : 4'(DATA_W - 1) - idx;
    endfunction

    always_comb begin
        wr_en       = spi_select & ~write_n;
        rd_en       = spi_select & ~read_n;
        hp_done     = (cnt_q == '0);
        tx_empty    = (tx_cnt_q == '0);
        tx_full     = (tx_cnt_q == DEPTH_C);
        rx_empty    = (rx_cnt_q == '0);
        rx_full     = (rx_cnt_q == DEPTH_C);
        tx_pop      = ~tx_empty & ((state_q == S_IDLE) | ((state_q == S_TRAIL) & hp_done));
        tx_push_req = wr_en & (mem_addr == 3'd1);
        tx_push     = tx_push_req & (~tx_full | tx_pop);
        toe_set     = tx_push_req & ~tx_push;
        rx_pop      = rd_en & (mem_addr == 3'd0) & ~rx_empty;
        rx_push_req = (state_q == S_TRAIL) & hp_done;
        rx_push     = rx_push_req & (~rx_full | rx_pop);
        roe_set     = rx_push_req & ~rx_push;
        tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d    = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        // Edge numbering starts at 1; odd/even parity against CPHA selects sample vs shift.
        edge_nx     = edge_q + 6'd1;
        sample_now  = edge_nx[0] ^ cpha_l_q;
        shift_now   = (edge_nx[0] == cpha_l_q) & (edge_nx != LAST_EDGE);
        samp_idx    = edge_nx[4:1] - 4'(cpha_l_q);
        status        = '0;
        status[0]     = tx_empty & (state_q == S_IDLE);
        status[1]     = ~tx_full;
        status[2]     = ~rx_empty;
        status[3]     = toe_q;
        status[4]     = roe_q;
        status[5]     = toe_q | roe_q;
        status[15:8]  = 8'(rx_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= data_from_cpu & WMASK;
        if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            cpol_l_q <= 1'b0;
            cpha_l_q <= 1'b0;
            lsb_l_q  <= 1'b0;
            div_l_q  <= '0;
            mask_l_q <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ss_n_q   <= '1;
            ctrl_q   <= '0;
            div_q    <= 16'(DIV_RESET);
            mask_q   <= NUM_SLAVES'(1);
            toe_q    <= 1'b0;
            roe_q    <= 1'b0;
            irq_q    <= 1'b0;
            dout_q   <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);

            if (wr_en) begin
                case (mem_addr)
                    3'd2: begin
                        toe_q <= 1'b0;
                        roe_q <= 1'b0;
                    end
                    3'd3:    ctrl_q <= data_from_cpu[6:0];
                    3'd4:    div_q  <= data_from_cpu;
                    3'd5:    mask_q <= data_from_cpu[NUM_SLAVES-1:0];
                    default: ;
                endcase
            end
            if (toe_set) toe_q <= 1'b1;
            if (roe_set) roe_q <= 1'b1;

            if (rd_en) begin
                case (mem_addr)
                    3'd0:    dout_q <= rx_empty ? '0 : rx_mem[rx_rp_q];
                    3'd2:    dout_q <= status;
                    3'd3:    dout_q <= 16'(ctrl_q);
                    3'd4:    dout_q <= div_q;
                    3'd5:    dout_q <= 16'(mask_q);
                    default: dout_q <= '0;
                endcase
            end
            irq_q <= (status[1] & ctrl_q[4]) | (status[2] & ctrl_q[5]) | (status[5] & ctrl_q[6]);

            // Config is snapshotted with each word so register writes mid-transfer wait for the next one.
            if (tx_pop) begin
                tx_sh_q  <= tx_mem[tx_rp_q];
                cpol_l_q <= ctrl_q[0];
                cpha_l_q <= ctrl_q[1];
                lsb_l_q  <= ctrl_q[2];
                div_l_q  <= div_q;
                mask_l_q <= mask_q;
                rx_sh_q  <= '0;
                edge_q   <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    sclk_q <= ctrl_q[0];
                    ss_n_q <= ctrl_q[3] ? ~mask_q : '1;
                    if (tx_pop) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    ss_n_q  <= ~mask_l_q;
                    sclk_q  <= cpol_l_q;
                    cnt_q   <= div_l_q;
                    if (!cpha_l_q) mosi_q <= tx_sh_q[bitpos(lsb_l_q, 4'd0)];
                    state_q <= S_LEAD;
                end
                S_LEAD, S_SHIFT: begin
                    if (!hp_done) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        sclk_q <= ~sclk_q;
                        cnt_q  <= div_l_q;
                        edge_q <= edge_nx;
                        if (sample_now) rx_sh_q[bitpos(lsb_l_q, samp_idx)] <= MISO;
                        if (shift_now)  mosi_q <= tx_sh_q[bitpos(lsb_l_q, edge_nx[4:1])];
                        state_q <= (edge_nx == LAST_EDGE) ? S_TRAIL : S_SHIFT;
                    end
                end
                S_TRAIL: begin
                    if (!hp_done) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (tx_pop) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                        ss_n_q  <= ctrl_q[3] ? ~mask_q : '1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_to_cpu = dout_q;
    assign irq         = irq_q;
    assign SCLK        = sclk_q;
    assign MOSI        = mosi_q;
    assign SS_n        = ss_n_q;
endmodule
